// File: rtl/pluse_timer_pkg.sv
// Shared definitions for the segment timer and its sequencer: state encoding
// and the default widths/timing constants both sides agree on.
package pluse_timer_pkg;

    localparam int unsigned CW_DEF     = 20;
    localparam int unsigned DIV_DEF    = 50;
    localparam int unsigned SETTLE_DEF = 2;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETTLE = 5'b00010,
        ST_COUNT  = 5'b00100,
        ST_FIRE   = 5'b01000,
        ST_DONE   = 5'b10000
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pluse_timer_if.sv
// Sequencer <-> segment timer link: control and timecount in, advance strobe
// and status out.
interface pluse_timer_if
    import pluse_timer_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
);
    logic          start;
    logic          abort;
    logic [CW-1:0] timecount;
    logic          state_over_n;
    logic          clken_p;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt_cur;

    modport master (
        output start, abort, timecount, state_over_n,
        input  clken_p, busy, done, cnt_cur
    );

    modport slave (
        input  start, abort, timecount, state_over_n,
        output clken_p, busy, done, cnt_cur
    );
endinterface

// File: rtl/pluse_timer_tick_gen.sv
// Time-unit prescaler: counts 0..DIV-1 and flags the last cycle of each unit.
module tick_gen
    import pluse_timer_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int unsigned PW = cnt_width(DIV);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          wrap;

    assign wrap   = (presc_q == PW'(DIV - 1));
    assign tick_o = en_i && !clr_i && wrap;

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
endmodule

// File: rtl/pluse_timer.sv
// Segment timer: loads the sequencer's timecount, counts it down in prescaled
// units and returns a one-cycle clken_p strobe per segment.
module pluse_timer
    import pluse_timer_pkg::*;
#(
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned DIV        = DIV_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_DEF
)(
    input logic        clk_sys,
    input logic        rst,
    pluse_timer_if.slave bus
);
    localparam int unsigned SW = cnt_width(SETTLE_CYC);

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          clken_q, busy_q, done_q;
    logic          tick;

    // Prescaler is held cleared outside COUNT, so every segment starts at 0.
    tick_gen #(.DIV(DIV)) u_tick (
        .clk_i  (clk_sys),
        .rst_i  (rst),
        .clr_i  (state_q != ST_COUNT),
        .en_i   (1'b1),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    cnt_d   = (bus.timecount == '0) ? CW'(1) : bus.timecount;
                    last_d  = ~bus.state_over_n;
                    state_d = ST_COUNT;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_COUNT: begin
                if (tick) begin
                    if (cnt_q >= CW'(2)) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                cnt_d    = '0;
                settle_d = '0;
                state_d  = last_q ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a COUNT->FIRE on the same edge.
        if (bus.abort) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            cnt_d    = '0;
            last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            clken_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            clken_q  <= (state_d == ST_FIRE);
            busy_q   <= (state_d == ST_SETTLE) || (state_d == ST_COUNT) || (state_d == ST_FIRE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign bus.clken_p = clken_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cnt_cur = cnt_q;
endmodule

// File: tb/tb_pluse_timer.sv
// Directed bench for pluse_timer with DIV=4, SETTLE_CYC=2.
module tb_pluse_timer;
    import pluse_timer_pkg::*;

    localparam int unsigned CW = 20;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    pluse_timer_if #(.CW(CW)) bus ();

    pluse_timer #(.CW(CW), .DIV(4), .SETTLE_CYC(2)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic          rst;
        logic          start;
        logic          abort;
        logic [CW-1:0] tc;
        logic          son;
        logic          e_clk;
        logic          e_busy;
        logic          e_done;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl [17];
    int   seg_n [8];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, bus.clken_p, bus.busy, bus.done, bus.cnt_cur};
    endfunction

    function automatic logic [31:0] mk(input logic c, input logic b, input logic d, input logic [CW-1:0] n);
        return {9'd0, c, b, d, n};
    endfunction

    // Steps until clken_p is seen; n counts edges taken.
    task automatic wait_strobe(input int maxc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < maxc) begin
            step();
            n++;
            if (bus.clken_p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic go_idle();
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
    endtask

    initial begin
        int  n;
        bit  ok;
        int  cyc, last, strobes, idx, extra;

        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.timecount    = '0;
        bus.state_over_n = 1'b1;

        // Reset and quiet idle
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outs", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        end

        // rst,start,abort,tc,son | clken,busy,done,cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 20'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 20'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b0, 1'b1, 1'b0, 20'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b0, 1'b1, 1'b0, 20'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b0, 1'b1, 1'b0, 20'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b1, 1'b1, 1'b0, 20'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b0, 1'b0, 1'b1, 20'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 20'd7, 1'b1, 1'b0, 1'b0, 1'b1, 20'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 20'd7, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 20'd7, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 20'd5, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 20'd5, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 20'd5, 1'b1, 1'b0, 1'b1, 1'b0, 20'd5};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 20'd5, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 20'd5, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0};

        for (int i = 0; i < 17; i++) begin
            rst              = tbl[i].rst;
            bus.start        = tbl[i].start;
            bus.abort        = tbl[i].abort;
            bus.timecount    = tbl[i].tc;
            bus.state_over_n = tbl[i].son;
            step();
            chk($sformatf("vec%0d", i), outs(),
                mk(tbl[i].e_clk, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt));
        end
        go_idle();

        // Single segment N=3: strobe 14 edges after the start edge, then reload
        bus.timecount    = 20'd3;
        bus.state_over_n = 1'b1;
        bus.start        = 1'b1;
        step();
        wait_strobe(100, n, ok);
        chk("seg3_strobe_found", 32'(ok), 32'd1);
        chk("seg3_latency", 32'(n), 32'd14);
        bus.timecount = 20'd9;
        step();
        chk("seg3_busy_after", 32'({bus.busy, bus.clken_p}), 32'b10);
        step();
        step();
        chk("seg3_next_load", 32'(bus.cnt_cur), 32'd9);
        go_idle();

        // Sequencer model: 8 segments, last one flagged by state_over_n low
        seg_n[0] = 10;  seg_n[1] = 100; seg_n[2] = 100; seg_n[3] = 400;
        seg_n[4] = 30;  seg_n[5] = 168; seg_n[6] = 7;   seg_n[7] = 1;
        idx              = 0;
        bus.timecount    = CW'(seg_n[0]);
        bus.state_over_n = 1'b1;
        bus.start        = 1'b1;
        step();
        cyc = 0; last = 0; strobes = 0;
        while (strobes < 8 && cyc < 5000) begin
            step();
            cyc++;
            if (bus.clken_p) begin
                chk($sformatf("seq_interval%0d", idx), 32'(cyc - last),
                    32'((idx == 0 ? 2 : 3) + 4 * seg_n[idx]));
                last = cyc;
                strobes++;
                idx++;
                if (idx < 8) begin
                    bus.timecount    = CW'(seg_n[idx]);
                    bus.state_over_n = (idx != 7);
                end
            end
        end
        chk("seq_strobe_count", 32'(strobes), 32'd8);
        step();
        chk("seq_done", outs(), mk(1'b0, 1'b0, 1'b1, '0));
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.clken_p || !bus.done) extra++;
        end
        chk("seq_hold_done_no_restart", 32'(extra), 32'd0);
        bus.start = 1'b0;
        step();
        chk("seq_done_release", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        go_idle();

        // Abort on the edge that would fire segment 2
        bus.timecount    = 20'd3;
        bus.state_over_n = 1'b1;
        bus.start        = 1'b1;
        step();
        wait_strobe(100, n, ok);
        chk("abort_seg1_latency", 32'(n), 32'd14);
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.clken_p) extra++;
        end
        chk("abort_pre_no_strobe", 32'(extra), 32'd0);
        chk("abort_pre_cnt", 32'(bus.cnt_cur), 32'd1);
        bus.abort = 1'b1;
        bus.start = 1'b0;
        step();
        chk("abort_wins", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        bus.abort = 1'b0;
        step();
        chk("abort_idle", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        bus.start = 1'b1;
        step();
        wait_strobe(100, n, ok);
        chk("abort_restart_latency", 32'(n), 32'd14);
        go_idle();

        // Reset mid-COUNT with cnt_cur=5
        bus.timecount = 20'd5;
        bus.start     = 1'b1;
        step();
        step();
        step();
        chk("rst_pre_cnt", 32'(bus.cnt_cur), 32'd5);
        rst = 1'b1;
        step();
        chk("rst_mid_count", outs(), mk(1'b0, 1'b0, 1'b0, '0));
        bus.start = 1'b0;
        step();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (outs() != mk(1'b0, 1'b0, 1'b0, '0)) extra++;
        end
        chk("rst_after_quiet", 32'(extra), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
